key_conditioner: RTL
====================

// Module: key_conditioner
// PURPOSE
//  Front-end stage feeding rpncalc: turns raw KEY[3:0] buttons and SW[17:0] switches into clean per-press commands.
//  Synchronises inputs, debounces each key and emits a one-cycle active-low onehot key pulse.
//  On the pulse cycle it also latches mode/val, so rpncalc sees one stable (mode,key,val) op per press.
// PARAMETERS
//  DEBOUNCE_CYCLES  4     consecutive stable sync samples needed to accept a key level change (>=2)
//  REPEAT_DELAY     32    cycles a key is held before the first auto-repeat (KEY_AUTOREPEAT_EN only)
//  REPEAT_PERIOD    8     cycles between later auto-repeats (KEY_AUTOREPEAT_EN only)
// PORTS
//  clk2      in   1   clock; reset rst, synchronous, active-low; clock clk2
//  rst       in   1   synchronous active-low reset
//  key_raw   in   4   raw buttons, active-low, asynchronous, may bounce
//  sw_raw    in   18  raw switches, asynchronous: [17:16]=mode, [15:0]=val
//  key       out  4   active-low onehot press pulse to rpncalc; 4'b1111 = idle
//  mode      out  2   mode latched on the pulse cycle; held until the next pulse
//  val       out  16  val latched on the pulse cycle; held until the next pulse
//  dropped   out  1   one-cycle pulse: a press event was discarded (see conflicts)
// BEHAVIOUR
//  - Reset (rst==0 at posedge clk2): key=4'b1111, mode=0, val=0, dropped=0.
//    Internal state on reset: sync flops keys=1111 and sw=0; debounced level=1111; counters=0; repeat timer=0.
//  - Sync: 2-flop synchroniser on every key_raw and sw_raw bit.
//  - Debounce, per key: cnt clears whenever sync==level.
//    While sync!=level, cnt increments; when cnt==DEBOUNCE_CYCLES-1 and sync!=level, level<=sync and cnt<=0.
//  - Press event = debounced level 1->0. Release (0->1) produces no output.
//  - Latency: raw fall first sampled at edge k, held clean thereafter.
//    level falls at edge k+1+DEBOUNCE_CYCLES; key pulse is registered at edge k+2+DEBOUNCE_CYCLES and lasts exactly 1 cycle.
//  - mode/val take the synced switch value in the same cycle as the pulse.
//  - Conflicts (pulse output is always onehot):
//    * Several events in one cycle: lowest index wins; others dropped, dropped=1.
//    * An event while another key is debounced-low is dropped; dropped=1, no pulse.
//  - Glitch shorter than DEBOUNCE_CYCLES samples: no level change, no pulse, no dropped.
//  - key returns to 4'b1111 the cycle after a pulse; no back-to-back pulses from one press.
//  - Reset mid-press: all outputs return to their reset values.
//    A key still held after reset release counts as a new press once debounced.
// CONFIGURATION
//  KEY_AUTOREPEAT_EN defined: while exactly one key stays debounced-low, the repeat timer counts.
//    First extra pulse comes REPEAT_DELAY cycles after the original pulse, then one every REPEAT_PERIOD cycles.
//    Each repeat re-latches mode/val. Release or a second key going low clears the timer.
//  KEY_AUTOREPEAT_EN undefined: exactly one pulse per press; timer logic not generated.
// STRUCTURE
//  key_cond_pkg: typedef logic [3:0] key_t; typedef logic [1:0] mode_t; localparam key_t KEY_NONE=4'b1111.
//    Also holds the onehot press encodings KEY0..KEY3 (1110,1101,1011,0111).
//  Sub-module key_debounce (DEBOUNCE_CYCLES): sync + counter + level for one bit; instantiated 4x.
//  Top handles event arbitration, switch latching, output regs and optional repeat timer.
// TESTING (DEBOUNCE_CYCLES=4, clk2 period 50)
//  - Reset: rst=0 for 2 edges -> key=1111, mode=0, val=0, dropped=0; rst=1 with keys idle -> outputs unchanged.
//  - Clean press: sw_raw=18'h2_1234, key_raw=1110 from edge k -> key=1110 at edge k+6 only, mode=2, val=1234.
//    key=1111 from k+7; hold 20 cycles -> no further pulse (macro off).
//  - Bounce: key_raw toggles 1101/1111 every cycle for 10 cycles, then holds 1101 -> single key=1101 pulse, 6 edges after the hold starts.
//  - Glitch: key_raw=1011 for 3 cycles then 1111 -> key stays 1111, dropped=0.
//  - Conflict: hold key0 past the debounce window, then press key2 -> dropped=1 for 1 cycle; key stays 1111.
//    Simultaneous clean fall of keys 1 and 3 -> key=1101 and dropped=1 in the same cycle.
//  - KEY_AUTOREPEAT_EN: hold key3 -> pulses 0111 at T, T+32, T+40, T+48; release -> pulses stop.
//    Reset mid-hold -> key=1111 at the next edge.

Source files
------------

// File: rtl/key_cond_pkg.sv
// Shared types and onehot press encodings for the key conditioner front end.
package key_cond_pkg;

  typedef logic [3:0] key_t;
  typedef logic [1:0] mode_t;

  localparam key_t KEY_NONE = 4'b1111;
  localparam key_t KEY0     = 4'b1110;
  localparam key_t KEY1     = 4'b1101;
  localparam key_t KEY2     = 4'b1011;
  localparam key_t KEY3     = 4'b0111;

  // Lowest set bit of an active-high event vector wins the active-low press code.
  function automatic key_t lowest_press(input logic [3:0] ev);
    key_t k;
    k = KEY_NONE;
    if (ev[3]) k = KEY3;
    if (ev[2]) k = KEY2;
    if (ev[1]) k = KEY1;
    if (ev[0]) k = KEY0;
    return k;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One-bit synchroniser plus debounce counter; level idles high (key released).
module key_debounce
  import key_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk2,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // Level follows sync2 only after it has disagreed for DEBOUNCE_CYCLES samples in a row.
  always_ff @(posedge clk2) begin
    if (!rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_conditioner.sv
// Turns raw keys/switches into one-cycle onehot press pulses with latched mode/val.
// Optional auto-repeat while a single key is held: define KEY_AUTOREPEAT_EN.
module key_conditioner
  import key_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
`ifdef KEY_AUTOREPEAT_EN
  , parameter int REPEAT_DELAY  = 32
  , parameter int REPEAT_PERIOD = 8
`endif
) (
  input  logic        clk2,
  input  logic        rst,
  input  logic [3:0]  key_raw,
  input  logic [17:0] sw_raw,
  output logic [3:0]  key,
  output logic [1:0]  mode,
  output logic [15:0] val,
  output logic        dropped
);

  key_t        level;
  key_t        level_d1;
  logic [17:0] sw_sync1;
  logic [17:0] sw_sync2;
  logic [3:0]  falls;
  logic [3:0]  held;
  logic        accept;
  logic        fire;
  key_t        next_key;
  logic        next_drop;
  mode_t       sw_mode;

  assign sw_mode = sw_sync2[17:16];

  for (genvar i = 0; i < 4; i++) begin : g_deb
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk2  (clk2),
      .rst   (rst),
      .raw   (key_raw[i]),
      .level (level[i])
    );
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int TW = $clog2(REPEAT_DELAY + 1);
  localparam logic [TW-1:0] RPT_LAST   = TW'(REPEAT_DELAY);
  localparam logic [TW-1:0] RPT_RELOAD = TW'(REPEAT_DELAY - REPEAT_PERIOD + 1);

  logic [3:0]    low;
  logic          one_low;
  logic [TW-1:0] rpt_timer;

  assign low     = ~level;
  assign one_low = (low != 4'b0000) && ((low & (low - 4'd1)) == 4'b0000);

  // Timer is 1 on the pulse cycle, so a repeat lands exactly REPEAT_DELAY cycles later.
  always_ff @(posedge clk2) begin
    if (!rst) begin
      rpt_timer <= '0;
    end else if (!one_low) begin
      rpt_timer <= '0;
    end else if (accept) begin
      rpt_timer <= TW'(1);
    end else if (rpt_timer == RPT_LAST) begin
      rpt_timer <= RPT_RELOAD;
    end else begin
      rpt_timer <= rpt_timer + 1'b1;
    end
  end
`endif

  // A new fall is refused while any other key is already held down.
  always_comb begin
    falls     = level_d1 & ~level;
    held      = ~level_d1 & ~level;
    next_key  = KEY_NONE;
    next_drop = 1'b0;
    accept    = 1'b0;
    fire      = 1'b0;
    if (falls != 4'b0000) begin
      if (held != 4'b0000) begin
        next_drop = 1'b1;
      end else begin
        accept    = 1'b1;
        fire      = 1'b1;
        next_key  = lowest_press(falls);
        next_drop = (falls & (falls - 4'd1)) != 4'b0000;
      end
    end
`ifdef KEY_AUTOREPEAT_EN
    else if (one_low && rpt_timer == RPT_LAST) begin
      fire     = 1'b1;
      next_key = level;
    end
`endif
  end

  always_ff @(posedge clk2) begin
    if (!rst) begin
      sw_sync1 <= '0;
      sw_sync2 <= '0;
      level_d1 <= KEY_NONE;
      key      <= KEY_NONE;
      dropped  <= 1'b0;
      mode     <= '0;
      val      <= '0;
    end else begin
      sw_sync1 <= sw_raw;
      sw_sync2 <= sw_sync1;
      level_d1 <= level;
      key      <= next_key;
      dropped  <= next_drop;
      if (fire) begin
        mode <= sw_mode;
        val  <= sw_sync2[15:0];
      end
    end
  end

endmodule
